ln_stats_reader: RTL

LN_STATS_READER -- requirements
Module: ln_stats_reader

---
 rtl/ln_stats_reader.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/ln_stats_reader.sv
// Per-pixel stats store and frame reader: buffers {mean, std} per pixel and replays
// each pixel once per channel group as a ready/valid beat stream.
module ln_stats_reader #(
    parameter int DAT_DW = 16,
    parameter int PIX_AW = 10,
    parameter int H_W    = 6,
    parameter int W_W    = 6,
    parameter int CG_W   = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [H_W-1:0]    h_in,
    input  logic [W_W-1:0]    w_in,
    input  logic [CG_W-1:0]   cg_in,
    input  logic              wr_vld,
    input  logic [PIX_AW-1:0] wr_addr,
    input  logic [DAT_DW-1:0] wr_mean,
    input  logic [DAT_DW+1:0] wr_std,
    input  logic              wr_done,
    output logic              rd_vld,
    input  logic              rd_rdy,
    output logic [DAT_DW-1:0] rd_mean,
    output logic [DAT_DW+1:0] rd_std,
    output logic [PIX_AW-1:0] rd_pix,
    output logic [CG_W-1:0]   rd_grp,
    output logic              rd_last,
    output logic              rd_done,
    output logic              busy,
    output logic              wr_err
);
    localparam int SW = DAT_DW + 2;
    localparam int RW = DAT_DW + SW;
    localparam int NW = (H_W + W_W > PIX_AW) ? (H_W + W_W) : PIX_AW;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_STREAM, S_DONE} state_t;
    state_t state_reg, state_next;

    logic [RW-1:0]     ram [0:(2**PIX_AW)-1];
    logic [RW-1:0]     ram_q_reg;

    logic [PIX_AW-1:0] last_pix_reg, iss_pix_reg, s1_pix_reg, skid_pix_reg;
    logic [CG_W-1:0]   last_grp_reg, iss_grp_reg, s1_grp_reg, skid_grp_reg;
    logic              iss_done_reg, s1_vld_reg, s1_last_reg;
    logic              skid_vld_reg, skid_last_reg, wr_err_reg;
    logic [RW-1:0]     skid_data_reg;

    logic wr_ok, start, issue, iss_last, s1_take, xfer;

    assign wr_ok    = wr_vld && (state_reg == S_IDLE);
    assign start    = wr_done && (state_reg == S_IDLE);
    assign iss_last = (iss_pix_reg == last_pix_reg) && (iss_grp_reg == last_grp_reg);
    // Reads stop whenever the skid holds a beat, so the RAM output register
    // never gets overwritten while its beat is still waiting downstream.
    assign issue    = ((state_reg == S_FETCH) || (state_reg == S_STREAM))
                      && !iss_done_reg && !skid_vld_reg;
    assign s1_take  = s1_vld_reg && !skid_vld_reg;
    assign xfer     = rd_vld && rd_rdy;

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            ram[wr_addr] <= {wr_mean, wr_std};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ram_q_reg <= '0;
        end else if (issue) begin
            ram_q_reg <= ram[iss_pix_reg];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:   if (start) state_next = S_FETCH;
            S_FETCH:  state_next = S_STREAM;
            S_STREAM: if (xfer && rd_last) state_next = S_DONE;
            S_DONE:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_pix_reg  <= '0;
            last_grp_reg  <= '0;
            iss_pix_reg   <= '0;
            iss_grp_reg   <= '0;
            iss_done_reg  <= 1'b0;
            s1_vld_reg    <= 1'b0;
            s1_pix_reg    <= '0;
            s1_grp_reg    <= '0;
            s1_last_reg   <= 1'b0;
            skid_vld_reg  <= 1'b0;
            skid_pix_reg  <= '0;
            skid_grp_reg  <= '0;
            skid_last_reg <= 1'b0;
            skid_data_reg <= '0;
            wr_err_reg    <= 1'b0;
        end else begin
            if (start) begin
                last_pix_reg <= PIX_AW'(NW'(h_in) * NW'(w_in) - NW'(1));
                last_grp_reg <= cg_in - CG_W'(1);
                iss_pix_reg  <= '0;
                iss_grp_reg  <= '0;
                iss_done_reg <= 1'b0;
            end else if (issue) begin
                if (iss_last) begin
                    iss_done_reg <= 1'b1;
                end else if (iss_grp_reg == last_grp_reg) begin
                    iss_grp_reg <= '0;
                    iss_pix_reg <= iss_pix_reg + PIX_AW'(1);
                end else begin
                    iss_grp_reg <= iss_grp_reg + CG_W'(1);
                end
            end

            if (issue) begin
                s1_vld_reg  <= 1'b1;
                s1_pix_reg  <= iss_pix_reg;
                s1_grp_reg  <= iss_grp_reg;
                s1_last_reg <= iss_last;
            end else if (s1_take) begin
                s1_vld_reg <= 1'b0;
            end

            // Beat parks in the skid when presented but not accepted.
            if (skid_vld_reg) begin
                if (rd_rdy) skid_vld_reg <= 1'b0;
            end else if (s1_vld_reg && !rd_rdy) begin
                skid_vld_reg  <= 1'b1;
                skid_pix_reg  <= s1_pix_reg;
                skid_grp_reg  <= s1_grp_reg;
                skid_last_reg <= s1_last_reg;
                skid_data_reg <= ram_q_reg;
            end

            if (wr_vld && (state_reg != S_IDLE)) begin
                wr_err_reg <= 1'b1;
            end
        end
    end

    assign rd_vld  = s1_vld_reg || skid_vld_reg;
    assign rd_mean = skid_vld_reg ? skid_data_reg[RW-1:SW] : ram_q_reg[RW-1:SW];
    assign rd_std  = skid_vld_reg ? skid_data_reg[SW-1:0] : ram_q_reg[SW-1:0];
    assign rd_pix  = skid_vld_reg ? skid_pix_reg : s1_pix_reg;
    assign rd_grp  = skid_vld_reg ? skid_grp_reg : s1_grp_reg;
    assign rd_last = skid_vld_reg ? skid_last_reg : (s1_vld_reg && s1_last_reg);
    assign rd_done = (state_reg == S_DONE);
    assign busy    = (state_reg != S_IDLE);
    assign wr_err  = wr_err_reg;
endmodule
